// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 (25.175 MHz pixel clock) segment lengths
// and sync polarity encodings used by vga_timing_gen parameter defaults.
// No ports; no latency or backpressure (constants only).
package vga_pkg;

    // Horizontal segments, in pixels
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    // Vertical segments, in lines
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Sync polarity: the level a sync output takes while its sync segment is running
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis: counts 0..TOTAL-1 on en, wraps to 0 after TOTAL-1.
// Latency: count updates on the clk edge after en; count_next/wrap are combinational look-ahead.
// Backpressure: none; holds while en=0. Ports: clk, reset, en in; count, count_next, wrap out.
module vga_axis_counter #(
    parameter  int TOTAL = 800,
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    // count_next is exposed so the parent can decode its outputs one cycle
    // ahead and register them alongside the count itself.
    always_comb begin
        wrap       = en && (count == LAST);
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (en) begin
            count_next = count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: line/frame counters, syncs, visible window, x/y and start pulses.
// Latency: all outputs are registered from next-state counts, so they change on the same edge as hcount/vcount.
// Backpressure: none; pix_en=0 freezes everything and forces start pulses low.
// Ports: clk, reset (async, active-high), pix_en in; hsync, vsync, hcount, vcount,
//        active_video, x, y, line_start, frame_start out.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter  int H_DISPLAY = DEF_H_DISPLAY,
    parameter  int H_FRONT   = DEF_H_FRONT,
    parameter  int H_SYNC    = DEF_H_SYNC,
    parameter  int H_BACK    = DEF_H_BACK,
    parameter  int V_DISPLAY = DEF_V_DISPLAY,
    parameter  int V_FRONT   = DEF_V_FRONT,
    parameter  int V_SYNC    = DEF_V_SYNC,
    parameter  int V_BACK    = DEF_V_BACK,
    parameter  bit HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter  bit VSYNC_POL = SYNC_ACTIVE_LOW,
    localparam int H_TOTAL   = H_SYNC + H_BACK + H_DISPLAY + H_FRONT,
    localparam int V_TOTAL   = V_SYNC + V_BACK + V_DISPLAY + V_FRONT,
    localparam int HCW       = $clog2(H_TOTAL),
    localparam int VCW       = $clog2(V_TOTAL)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_en,
    output logic           hsync,
    output logic           vsync,
    output logic [HCW-1:0] hcount,
    output logic [VCW-1:0] vcount,
    output logic           active_video,
    output logic [HCW-1:0] x,
    output logic [VCW-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    generate
        if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
            V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_timing
            $error("vga_timing_gen: every timing segment must be at least 1");
        end
    endgenerate

    // Segment boundaries; count 0 is the first sync cycle, then back porch, display, front porch.
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_SYNC);
    localparam logic [HCW-1:0] H_ACT_BEG  = HCW'(H_SYNC + H_BACK);
    localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_SYNC + H_BACK + H_DISPLAY);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_SYNC);
    localparam logic [VCW-1:0] V_ACT_BEG  = VCW'(V_SYNC + V_BACK);
    localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_SYNC + V_BACK + V_DISPLAY);

    logic [HCW-1:0] h_next;
    logic [VCW-1:0] v_next;
    logic           h_wrap;
    logic           v_wrap;
    logic           h_vis;
    logic           v_vis;

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_hcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (pix_en),
        .count      (hcount),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    // The vertical axis steps once per horizontal wrap; its wrap therefore
    // marks the last pixel of the frame being consumed.
    vga_axis_counter #(.TOTAL(V_TOTAL)) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap),
        .count      (vcount),
        .count_next (v_next),
        .wrap       (v_wrap)
    );

    always_comb begin
        h_vis = (h_next >= H_ACT_BEG) && (h_next < H_ACT_END);
        v_vis = (v_next >= V_ACT_BEG) && (v_next < V_ACT_END);
    end

    // Decoding from next-state counts keeps every output aligned with
    // hcount/vcount in the same cycle, with no combinational path from pix_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync        <= HSYNC_POL;
            vsync        <= VSYNC_POL;
            active_video <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (pix_en) begin
            hsync        <= (h_next < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync        <= (v_next < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
            active_video <= h_vis && v_vis;
            x            <= (h_vis && v_vis) ? (h_next - H_ACT_BEG) : '0;
            y            <= (h_vis && v_vis) ? (v_next - V_ACT_BEG) : '0;
            line_start   <= h_wrap;
            frame_start  <= v_wrap;
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end
    end

endmodule
